seven_segment_scan_decoder: RTL

Monitors a time-multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode enables) and recovers the hex digit shown on each position. It is the receive side of the hex-to-segment encoding used by the display path: decoded values, per-digit validity and error flags are used for self-checking on the board and for loop-back tests. The block sits in the `clk` domain, directly on the segment/anode nets driven by the display scanner.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_pattern_decode.sv | 26 ++
 rtl/seven_segment_scan_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: the active-low glyph table for 0-F,
// the blank/illegal marker and the scan-decoder FSM states.
package seg7_pkg;

  // Active-low codes, bit 0 = a ... bit 6 = g; entry i is the glyph for hex i.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse lookup: active-low segment pattern to {valid, hex}.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] hex
);

  logic [15:0] hit;

  for (genvar gi = 0; gi < 16; gi++) begin : g_cmp
    assign hit[gi] = (seg == SEG7_TABLE[gi]);
  end

  // Table entries are distinct, so at most one hit is ever set.
  always_comb begin
    hex = '0;
    for (int i = 0; i < 16; i++) begin
      if (hit[i]) hex = hex | 4'(i);
    end
  end

  assign valid = |hit;

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Receive side of a multiplexed active-low seven-segment bus: waits for each
// stable scan window, decodes the shown digit once, and commits it after confirmation.
module seven_segment_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int SETTLE  = 2,
  parameter int CONFIRM = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            s_seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  upd,
  output logic                  err_pat,
  output logic                  err_multi
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int KW = $clog2(CONFIRM + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LW = $clog2(DIGITS + 1);

  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;
  logic [CW-1:0]     stable_cnt;
  scan_state_t       state, state_next;
  logic              sample;
  logic              any_low;
  logic [LW-1:0]     low_cnt;
  logic [IW-1:0]     an_idx;
  logic              multi;
  logic              dec_valid;
  logic [3:0]        dec_hex;
  logic [DIGITS-1:0] sel;
  logic [DIGITS-1:0] digit_upd;

  // The counter tracks how many edges the registered pair has stayed put;
  // a change is detected as the new value lands in the input register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg      <= SEG7_BLANK;
      r_an       <= '1;
      stable_cnt <= '0;
    end else begin
      r_seg <= s_seg;
      r_an  <= an;
      if (s_seg != r_seg || an != r_an)
        stable_cnt <= '0;
      else if (stable_cnt != CW'(SETTLE))
        stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign any_low = ~&r_an;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    sample     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_low) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!any_low) begin
          state_next = ST_IDLE;
        end else if (stable_cnt == CW'(SETTLE)) begin
          sample     = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A saturated counter that has dropped means the window changed.
        if (!any_low)
          state_next = ST_IDLE;
        else if (stable_cnt != CW'(SETTLE))
          state_next = ST_SETTLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    low_cnt = '0;
    an_idx  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_an[i]) begin
        low_cnt = low_cnt + 1'b1;
        an_idx  = IW'(i);
      end
    end
  end

  assign multi = (low_cnt > LW'(1));

  seg7_pattern_decode u_decode (
    .seg   (r_seg),
    .valid (dec_valid),
    .hex   (dec_hex)
  );

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0]    cand;
    logic [KW-1:0] ccnt;
    logic [KW-1:0] ccnt_next;
    logic [3:0]    hex_q;
    logic          valid_q;

    assign sel[gi] = sample && !multi && (an_idx == IW'(gi));

    always_comb begin
      ccnt_next = KW'(1);
      if (dec_hex == cand)
        ccnt_next = (ccnt == KW'(CONFIRM)) ? ccnt : KW'(ccnt + 1'b1);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cand    <= '0;
        ccnt    <= '0;
        hex_q   <= '0;
        valid_q <= 1'b0;
      end else if (sel[gi]) begin
        if (!dec_valid) begin
          ccnt    <= '0;
          valid_q <= 1'b0;
        end else begin
          cand <= dec_hex;
          ccnt <= ccnt_next;
          if (ccnt_next == KW'(CONFIRM)) begin
            hex_q   <= dec_hex;
            valid_q <= 1'b1;
          end
        end
      end
    end

    assign digit_upd[gi] = sel[gi] && dec_valid && (ccnt_next == KW'(CONFIRM)) &&
                           (!valid_q || hex_q != dec_hex);
    assign hex_out[4*gi +: 4] = hex_q;
    assign digit_valid[gi]    = valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd       <= 1'b0;
      err_pat   <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      upd       <= |digit_upd;
      err_pat   <= sample && !multi && !dec_valid;
      err_multi <= sample && multi;
    end
  end

endmodule
